fb_write_arbiter: RTL and testbench
===================================

Name: fb_write_arbiter

Overview:
- Owns the single NES-side write port of the VGA frame buffer (256x240, 8-bit entries, address = {row[7:0], col[7:0]}) in the clk_ppu domain.
- Shares that port between three requesters:
  - the PPU pixel stream (fixed-timing, cannot stall);
  - a frame-clear engine (fill whole buffer with one colour on command);
  - an OSD/debug overlay writer with a req/ack handshake.
- Outputs feed the frame buffer's port A directly; the VGA read side is untouched.

Parameters:
- PPU_HDISP, 9'd256, visible PPU pixels per line
- PPU_VDISP, 9'd240, visible PPU lines
- PPU_DELAY, 9'd3, PPU pipeline latency from hcnt to valid ppu_pixel
- CLR_SYNC, 1'b1, 1 = clear waits for start of PPU vblank; 0 = clear starts immediately

Ports:
- clk_ppu  in  1  PPU clock, sole clock of the block
- reset  in  1  synchronous, active-high reset
- ppu_pixel  in  8  PPU pixel value
- ppu_hcnt  in  9  PPU horizontal counter
- ppu_vcnt  in  9  PPU vertical counter
- clr_start  in  1  one-cycle clear request
- clr_color  in  6  fill colour, sampled on accepted clr_start
- clr_busy  out  1  clear pending or in progress
- clr_done  out  1  one-cycle pulse after last clear write issued
- osd_req  in  1  OSD write request; held with addr/data until ack
- osd_addr  in  16  OSD target address {row, col}
- osd_data  in  8  OSD write data
- osd_ack  out  1  combinational; OSD request consumed this cycle
- osd_oob  out  1  one-cycle pulse: consumed request had row >= PPU_VDISP, write dropped
- fb_addr  out  16  frame buffer write address
- fb_data  out  8  frame buffer write data
- fb_wren  out  1  frame buffer write enable

Behaviour:
- Reset values:
  - fb_wren=0, fb_addr=0, fb_data=0;
  - clr_busy=0, clr_done=0, osd_oob=0;
  - clear FSM in IDLE, clear counter=0, latched colour=0.
- PPU window (combinational, per cycle):
  - lsb = ppu_hcnt - PPU_DELAY, 9-bit wrap;
  - ppu_win = (lsb < PPU_HDISP) && (ppu_vcnt < PPU_VDISP);
  - PPU address = {ppu_vcnt[7:0], lsb[7:0]}.
- Priority each cycle: PPU (ppu_win) > CLEAR (FSM in CLEAR) > OSD (osd_req). Exactly one source, or none, is granted.
- Outputs are registered, one-cycle latency: the grant decided in cycle N appears on fb_addr/fb_data/fb_wren in cycle N+1.
  - With no grant, fb_wren=0 and fb_addr/fb_data hold their previous values.
- Clear FSM states: IDLE, WAIT_VBL, CLEAR.
  - IDLE + clr_start: latch {2'b00, clr_color}, counter=0. Go to WAIT_VBL if CLR_SYNC=1, else to CLEAR.
  - WAIT_VBL -> CLEAR on the first cycle with ppu_vcnt == PPU_VDISP.
  - CLEAR:
    - Each cycle the clear source is granted, issue a write at the counter address, then counter += 1.
    - No advance in cycles lost to the PPU.
    - The write at counter 16'hEFFF is the last one: the FSM returns to IDLE and clr_done pulses in the following cycle, aligned with the last fb_wren.
- clr_busy = (state != IDLE).
- clr_start while busy is ignored; no re-latch, no restart.
- Counter is 16-bit and linear. Rows 0..239 map directly because the row occupies the upper byte; 240*256 = 16'hF000.
- OSD handshake:
  - osd_ack=1 iff osd_req && !ppu_win && state != CLEAR. OSD is therefore blocked (not starved indefinitely) while a clear runs.
  - In WAIT_VBL the OSD is still served; its writes will then be overwritten by the clear.
  - On ack with osd_addr >= 16'hF000: no write is issued, and osd_oob pulses in the next cycle.
  - Requester may drop osd_req only after ack; a new request may be presented the cycle after ack.
- Reset mid-clear: FSM to IDLE immediately, no clr_done, partial fill remains in the buffer.

Decomposition:
- Shared package (nes_vga_pkg): PPU_HDISP, PPU_VDISP, PPU_DELAY, FB_LAST_ADDR=16'hEFFF, and enum clr_state_t {IDLE, WAIT_VBL, CLEAR}.
- One natural sub-module: fb_clear_engine (FSM, counter, colour latch, done pulse). It takes a grant input and provides a request output.
- Arbitration and output registers stay in the top level.

Test Plan:
- PPU only, vcnt=5, hcnt=3..258 with pixel = hcnt[7:0] -> fb_wren is high for exactly 256 cycles, addresses 16'h0500..16'h05FF, first write one cycle after hcnt=3; no writes for hcnt=0..2 or hcnt=259+.
- CLR_SYNC=1, clr_start with colour 6'h21 at vcnt=100 -> clr_busy=1 at once, first clear write only after vcnt reaches 240, then 61440 writes of 8'h21 covering 16'h0000..16'hEFFF with no gaps or duplicates, then clr_done=1 for one cycle and clr_busy=0.
- Clear spanning the PPU window -> clear writes pause exactly during ppu_win cycles, no address is skipped, and PPU writes stay intact and ordered.
- osd_req with addr 16'h1234, data 8'h3F during ppu_win -> osd_ack stays 0 until ppu_win drops; next cycle fb_addr=16'h1234, fb_data=8'h3F, fb_wren=1. Repeat with addr 16'hF010 -> ack given, fb_wren=0, osd_oob pulses.
- OSD held during CLEAR -> no ack until clr_done; second clr_start mid-clear is ignored (colour unchanged, total write count still 61440).
- Reset asserted at clear counter 16'h4000 -> next cycle clr_busy=0, fb_wren=0, no clr_done; a fresh clr_start restarts from 16'h0000.

Source files
------------

// File: rtl/nes_vga_pkg.sv
// nes_vga_pkg: shared NES/VGA frame buffer geometry and clear FSM states
package nes_vga_pkg;
    localparam logic [8:0]  PPU_HDISP    = 9'd256;
    localparam logic [8:0]  PPU_VDISP    = 9'd240;
    localparam logic [8:0]  PPU_DELAY    = 9'd3;
    localparam logic [15:0] FB_LAST_ADDR = 16'hEFFF;
    localparam logic [15:0] FB_END_ADDR  = 16'hF000;
    typedef enum logic [1:0] {IDLE, WAIT_VBL, CLEAR} clr_state_t;
endpackage

// File: rtl/fb_write_arbiter_clear.sv
// fb_clear_engine: fills the frame buffer with one colour, advancing only on granted cycles
module fb_clear_engine
    import nes_vga_pkg::*;
#(
    parameter logic CLR_SYNC = 1'b1
) (
    input  logic        clk_ppu,
    input  logic        reset,
    input  logic        clr_start,
    input  logic [5:0]  clr_color,
    input  logic [8:0]  ppu_vcnt,
    input  logic        grant,
    output logic        req,
    output logic [15:0] addr,
    output logic [7:0]  data,
    output logic        busy,
    output logic        done
);
    clr_state_t state, state_nx;
    logic start, last;
    assign start = state == IDLE && clr_start;
    assign last  = grant && addr == FB_LAST_ADDR;
    assign req   = state == CLEAR;
    assign busy  = state != IDLE;
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE)     ? (clr_start ? (CLR_SYNC ? WAIT_VBL : CLEAR) : IDLE) :
                   (state == WAIT_VBL) ? (ppu_vcnt == PPU_VDISP ? CLEAR : WAIT_VBL) :
                   (last ? IDLE : CLEAR);
    end
    always_ff @(posedge clk_ppu) begin
        if (reset) begin
            state <= IDLE;
            addr  <= '0;
            data  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= last;
            if (start) begin
                addr <= '0;
                data <= {2'b00, clr_color};
            end else if (grant) begin
                addr <= addr + 16'd1;
            end
        end
    end
endmodule

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: shares the frame buffer write port between PPU, clear engine and OSD
module fb_write_arbiter
    import nes_vga_pkg::*;
#(
    parameter logic CLR_SYNC = 1'b1
) (
    input  logic        clk_ppu,
    input  logic        reset,
    input  logic [7:0]  ppu_pixel,
    input  logic [8:0]  ppu_hcnt,
    input  logic [8:0]  ppu_vcnt,
    input  logic        clr_start,
    input  logic [5:0]  clr_color,
    output logic        clr_busy,
    output logic        clr_done,
    input  logic        osd_req,
    input  logic [15:0] osd_addr,
    input  logic [7:0]  osd_data,
    output logic        osd_ack,
    output logic        osd_oob,
    output logic [15:0] fb_addr,
    output logic [7:0]  fb_data,
    output logic        fb_wren
);
    logic [8:0]  lsb;
    logic        ppu_win, clr_req, clr_grant, osd_wr, wr_any;
    logic [15:0] clr_addr, wr_addr;
    logic [7:0]  clr_data, wr_data;
    fb_clear_engine #(.CLR_SYNC(CLR_SYNC)) u_clear (
        .clk_ppu  (clk_ppu),
        .reset    (reset),
        .clr_start(clr_start),
        .clr_color(clr_color),
        .ppu_vcnt (ppu_vcnt),
        .grant    (clr_grant),
        .req      (clr_req),
        .addr     (clr_addr),
        .data     (clr_data),
        .busy     (clr_busy),
        .done     (clr_done)
    );
    assign lsb       = ppu_hcnt - PPU_DELAY;
    assign ppu_win   = lsb < PPU_HDISP && ppu_vcnt < PPU_VDISP;
    assign clr_grant = clr_req && !ppu_win;
    assign osd_ack   = osd_req && !ppu_win && !clr_req;
    // out-of-range OSD rows are consumed but never written
    assign osd_wr    = osd_ack && osd_addr < FB_END_ADDR;
    assign wr_any    = ppu_win || clr_grant || osd_wr;
    assign wr_addr   = ppu_win ? {ppu_vcnt[7:0], lsb[7:0]} : clr_grant ? clr_addr : osd_addr;
    assign wr_data   = ppu_win ? ppu_pixel : clr_grant ? clr_data : osd_data;
    always_ff @(posedge clk_ppu) begin
        if (reset) begin
            fb_wren <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
            osd_oob <= 1'b0;
        end else begin
            fb_wren <= wr_any;
            osd_oob <= osd_ack && !osd_wr;
            if (wr_any) begin
                fb_addr <= wr_addr;
                fb_data <= wr_data;
            end
        end
    end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: directed self-checking bench for the frame buffer write arbiter
module tb_fb_write_arbiter;
    logic        clk_ppu = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  ppu_pixel = '0;
    logic [8:0]  ppu_hcnt = '0;
    logic [8:0]  ppu_vcnt = 9'd241;
    logic        clr_start = 1'b0;
    logic [5:0]  clr_color = '0;
    logic        clr_busy, clr_done;
    logic        osd_req = 1'b0;
    logic [15:0] osd_addr = '0;
    logic [7:0]  osd_data = '0;
    logic        osd_ack, osd_oob;
    logic [15:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_wren;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_ppu = ~clk_ppu;

    fb_write_arbiter dut (
        .clk_ppu  (clk_ppu),
        .reset    (reset),
        .ppu_pixel(ppu_pixel),
        .ppu_hcnt (ppu_hcnt),
        .ppu_vcnt (ppu_vcnt),
        .clr_start(clr_start),
        .clr_color(clr_color),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .osd_req  (osd_req),
        .osd_addr (osd_addr),
        .osd_data (osd_data),
        .osd_ack  (osd_ack),
        .osd_oob  (osd_oob),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .fb_wren  (fb_wren)
    );

    task automatic tick();
        @(posedge clk_ppu);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({fb_wren, fb_addr, fb_data} !== 25'd0) begin
            n_bad++;
            $display("FAIL reset_fb: got %b/%h/%h want 0/0000/00", fb_wren, fb_addr, fb_data);
        end
        n_cmp++;
        if ({clr_busy, clr_done, osd_oob} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_flags: got busy/done/oob %b want 000", {clr_busy, clr_done, osd_oob});
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if ({fb_wren, clr_busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_idle: got wren/busy %b want 00", {fb_wren, clr_busy});
        end
    endtask

    task automatic test_ppu_only();
        int wr = 0;
        ppu_vcnt = 9'd5;
        for (int h = 0; h < 262; h++) begin
            logic [8:0] hv;
            logic [7:0] lo;
            logic       exp_w;
            hv = 9'(h);
            lo = 8'(h - 3);
            exp_w = h >= 3 && h <= 258;
            ppu_hcnt = hv;
            ppu_pixel = hv[7:0];
            tick();
            n_cmp++;
            if (fb_wren !== exp_w) begin
                n_bad++;
                $display("FAIL ppu_wren h=%0d: got %b want %b", h, fb_wren, exp_w);
            end
            if (exp_w) begin
                wr++;
                n_cmp++;
                if ({fb_addr, fb_data} !== {8'h05, lo, hv[7:0]}) begin
                    n_bad++;
                    $display("FAIL ppu_write h=%0d: got %h/%h want %h%h/%h", h, fb_addr, fb_data, 8'h05, lo, hv[7:0]);
                end
            end
        end
        n_cmp++;
        if (wr != 256) begin
            n_bad++;
            $display("FAIL ppu_count: got %0d want 256", wr);
        end
        ppu_vcnt = 9'd241;
        ppu_hcnt = 9'd0;
    endtask

    task automatic test_osd();
        ppu_vcnt = 9'd5;
        ppu_hcnt = 9'd100;
        ppu_pixel = 8'hAA;
        osd_req = 1'b1;
        osd_addr = 16'h1234;
        osd_data = 8'h3F;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (osd_ack !== 1'b0) begin
                n_bad++;
                $display("FAIL osd_blocked_by_ppu: got ack %b want 0", osd_ack);
            end
            tick();
        end
        ppu_hcnt = 9'd300;
        #1;
        n_cmp++;
        if (osd_ack !== 1'b1) begin
            n_bad++;
            $display("FAIL osd_ack: got %b want 1", osd_ack);
        end
        tick();
        osd_req = 1'b0;
        n_cmp++;
        if ({fb_wren, fb_addr, fb_data} !== {1'b1, 16'h1234, 8'h3F}) begin
            n_bad++;
            $display("FAIL osd_write: got %b/%h/%h want 1/1234/3f", fb_wren, fb_addr, fb_data);
        end
        n_cmp++;
        if (osd_oob !== 1'b0) begin
            n_bad++;
            $display("FAIL osd_oob_inrange: got %b want 0", osd_oob);
        end
        osd_req = 1'b1;
        osd_addr = 16'hF010;
        osd_data = 8'h07;
        #1;
        n_cmp++;
        if (osd_ack !== 1'b1) begin
            n_bad++;
            $display("FAIL osd_oob_ack: got %b want 1", osd_ack);
        end
        tick();
        osd_req = 1'b0;
        n_cmp++;
        if ({fb_wren, osd_oob, fb_addr} !== {1'b0, 1'b1, 16'h1234}) begin
            n_bad++;
            $display("FAIL osd_oob_drop: got wren/oob/addr %b/%b/%h want 0/1/1234", fb_wren, osd_oob, fb_addr);
        end
        tick();
        n_cmp++;
        if (osd_oob !== 1'b0) begin
            n_bad++;
            $display("FAIL osd_oob_pulse: got %b want 0", osd_oob);
        end
        ppu_vcnt = 9'd241;
        ppu_hcnt = 9'd0;
    endtask

    task automatic test_clear_full();
        int         writes = 0;
        logic [15:0] exp_a = '0;
        logic       done_seen = 1'b0;
        ppu_vcnt = 9'd100;
        ppu_hcnt = 9'd0;
        clr_color = 6'h21;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        clr_color = 6'h00;
        n_cmp++;
        if (clr_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_busy_start: got %b want 1", clr_busy);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (fb_wren !== 1'b0) begin
                n_bad++;
                $display("FAIL clr_wait_vbl: got wren %b want 0", fb_wren);
            end
        end
        osd_req = 1'b1;
        osd_addr = 16'h0100;
        osd_data = 8'h11;
        #1;
        n_cmp++;
        if (osd_ack !== 1'b1) begin
            n_bad++;
            $display("FAIL osd_in_wait_vbl: got ack %b want 1", osd_ack);
        end
        tick();
        osd_req = 1'b0;
        n_cmp++;
        if ({fb_wren, fb_addr, fb_data} !== {1'b1, 16'h0100, 8'h11}) begin
            n_bad++;
            $display("FAIL osd_wait_vbl_write: got %b/%h/%h want 1/0100/11", fb_wren, fb_addr, fb_data);
        end
        ppu_vcnt = 9'd240;
        tick();
        n_cmp++;
        if (fb_wren !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_vbl_edge: got wren %b want 0", fb_wren);
        end
        osd_req = 1'b1;
        osd_addr = 16'h2000;
        osd_data = 8'h05;
        for (int i = 0; i < 63000 && !done_seen; i++) begin
            logic        pw, exp_done;
            logic [15:0] pa;
            logic [7:0]  pd;
            if (i >= 2000 && i < 2262) begin
                ppu_vcnt = 9'd10;
                ppu_hcnt = 9'(i - 2000);
            end else begin
                ppu_vcnt = 9'd240;
                ppu_hcnt = 9'd0;
            end
            ppu_pixel = ppu_hcnt[7:0];
            clr_start = (i == 5000) ? 1'b1 : 1'b0;
            clr_color = 6'h3F;
            pw = ppu_hcnt >= 9'd3 && ppu_hcnt <= 9'd258 && ppu_vcnt < 9'd240;
            pa = {ppu_vcnt[7:0], 8'(ppu_hcnt - 9'd3)};
            pd = ppu_pixel;
            #1;
            n_cmp++;
            if (osd_ack !== 1'b0) begin
                n_bad++;
                $display("FAIL osd_blocked_by_clear i=%0d: got ack %b want 0", i, osd_ack);
            end
            tick();
            exp_done = 1'b0;
            if (pw) begin
                n_cmp++;
                if ({fb_wren, fb_addr, fb_data} !== {1'b1, pa, pd}) begin
                    n_bad++;
                    $display("FAIL clr_ppu_write i=%0d: got %b/%h/%h want 1/%h/%h", i, fb_wren, fb_addr, fb_data, pa, pd);
                end
            end else begin
                n_cmp++;
                if ({fb_wren, fb_addr, fb_data} !== {1'b1, exp_a, 8'h21}) begin
                    n_bad++;
                    $display("FAIL clr_write i=%0d: got %b/%h/%h want 1/%h/21", i, fb_wren, fb_addr, fb_data, exp_a);
                end
                writes++;
                exp_a = exp_a + 16'd1;
                exp_done = writes == 61440;
            end
            n_cmp++;
            if (clr_done !== exp_done) begin
                n_bad++;
                $display("FAIL clr_done_timing i=%0d: got %b want %b", i, clr_done, exp_done);
            end
            done_seen = clr_done === 1'b1;
        end
        clr_start = 1'b0;
        clr_color = 6'h00;
        n_cmp++;
        if (done_seen !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_timeout: got done_seen %b want 1", done_seen);
        end
        n_cmp++;
        if (writes != 61440) begin
            n_bad++;
            $display("FAIL clr_count: got %0d want 61440", writes);
        end
        n_cmp++;
        if (clr_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_busy_end: got %b want 0", clr_busy);
        end
        #1;
        n_cmp++;
        if (osd_ack !== 1'b1) begin
            n_bad++;
            $display("FAIL osd_after_clear: got ack %b want 1", osd_ack);
        end
        tick();
        osd_req = 1'b0;
        n_cmp++;
        if ({fb_wren, fb_addr, fb_data, clr_done} !== {1'b1, 16'h2000, 8'h05, 1'b0}) begin
            n_bad++;
            $display("FAIL osd_post_clear: got %b/%h/%h done %b want 1/2000/05 done 0", fb_wren, fb_addr, fb_data, clr_done);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic found = 1'b0;
        ppu_vcnt = 9'd240;
        ppu_hcnt = 9'd0;
        clr_color = 6'h0A;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 20000 && !found; i++) begin
            tick();
            found = fb_wren === 1'b1 && fb_addr === 16'h3FFF;
        end
        n_cmp++;
        if (found !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_reach_4000: got found %b want 1", found);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({clr_busy, fb_wren, clr_done, fb_addr} !== 19'd0) begin
            n_bad++;
            $display("FAIL rst_mid_clear: got busy/wren/done %b addr %h want 000 addr 0000", {clr_busy, fb_wren, clr_done}, fb_addr);
        end
        tick();
        n_cmp++;
        if ({clr_busy, fb_wren, clr_done} !== 3'b000) begin
            n_bad++;
            $display("FAIL rst_no_done: got busy/wren/done %b want 000", {clr_busy, fb_wren, clr_done});
        end
        clr_color = 6'h15;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({fb_wren, fb_addr, fb_data} !== {1'b1, 16'h0000, 8'h15}) begin
            n_bad++;
            $display("FAIL rst_restart0: got %b/%h/%h want 1/0000/15", fb_wren, fb_addr, fb_data);
        end
        tick();
        n_cmp++;
        if ({fb_wren, fb_addr, fb_data} !== {1'b1, 16'h0001, 8'h15}) begin
            n_bad++;
            $display("FAIL rst_restart1: got %b/%h/%h want 1/0001/15", fb_wren, fb_addr, fb_data);
        end
    endtask

    initial begin
        test_reset();
        test_ppu_only();
        test_osd();
        test_clear_full();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
